rv32im_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data/instruction memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the rv32im core. It grants one requester at a time, holds the memory request stable across memory wait states, and returns read data or write acknowledge to the owner. It sits between `rv32im_lsu`/IFU and the memory bus.

---
 rtl/rv32im_mem_arbiter_pkg.sv | 29 ++
 rtl/rv32im_mem_arbiter_if.sv | 50 +++++
 rtl/rv32im_memarb_pick.sv | 34 +++
 rtl/rv32im_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_rv32im_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32im_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM state and owner encodings.
// Supplies API_DATA_WIDTH / LSU_OPCODE_WIDTH defaults when no core-wide header defines them.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif

package rv32im_mem_arbiter_pkg;

  localparam int unsigned MEMARB_DATA_W = `API_DATA_WIDTH;

  typedef enum logic [1:0] {
    MEMARB_IDLE     = 2'd0,
    MEMARB_BUSY_IFU = 2'd1,
    MEMARB_BUSY_LSU = 2'd2
  } memarb_state_e;

  typedef enum logic {
    MEMARB_OWNER_IFU = 1'b0,
    MEMARB_OWNER_LSU = 1'b1
  } memarb_owner_e;

  function automatic memarb_state_e memarb_busy_state(input memarb_owner_e owner);
    return (owner == MEMARB_OWNER_LSU) ? MEMARB_BUSY_LSU : MEMARB_BUSY_IFU;
  endfunction

endpackage

// File: rtl/rv32im_mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side signals of the arbiter; slave = arbiter side,
// master = requesters plus memory.
interface rv32im_mem_arbiter_if
  import rv32im_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = MEMARB_DATA_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
);
  logic              ifu_req_i;
  logic [ADDR_W-1:0] ifu_addr_i;
  logic              ifu_gnt_o;
  logic              ifu_rvalid_o;
  logic [DATA_W-1:0] ifu_rdata_o;

  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [BE_W-1:0]   lsu_be_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [DATA_W-1:0] lsu_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  ifu_req_i, ifu_addr_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport master (
    output ifu_req_i, ifu_addr_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/rv32im_memarb_pick.sv
// Combinational winner selection between IFU and LSU requests.
// API_MEMARB_RR_EN selects round-robin on conflicts; otherwise the LSU always wins.
module rv32im_memarb_pick
  import rv32im_mem_arbiter_pkg::*;
(
  input  logic          ifu_req_i,
  input  logic          lsu_req_i,
  input  memarb_owner_e last_owner_i,
  output logic          valid_o,
  output memarb_owner_e owner_o
);

  always_comb begin
    valid_o = ifu_req_i | lsu_req_i;
    owner_o = MEMARB_OWNER_IFU;
`ifdef API_MEMARB_RR_EN
    if (ifu_req_i && lsu_req_i) begin
      owner_o = (last_owner_i == MEMARB_OWNER_IFU) ? MEMARB_OWNER_LSU : MEMARB_OWNER_IFU;
    end else if (lsu_req_i) begin
      owner_o = MEMARB_OWNER_LSU;
    end
`else
    if (lsu_req_i) begin
      owner_o = MEMARB_OWNER_LSU;
    end
`endif
  end

`ifndef API_MEMARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/rv32im_mem_arbiter.sv
// Shares one memory port between IFU and LSU: grant in IDLE, hold request through
// wait states, return rdata/ack to the owner. API_MEMARB_RR_EN enables round-robin.
module rv32im_mem_arbiter
  import rv32im_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = MEMARB_DATA_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
)(
  input logic                  clk_i,
  input logic                  rst_n_i,
  rv32im_mem_arbiter_if.slave  bus
);

  memarb_state_e     state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ifu_rvalid_q, ifu_rvalid_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              ifu_gnt, lsu_gnt;
  logic              pick_valid;
  memarb_owner_e     pick_owner;
  memarb_owner_e     last_owner;

`ifdef API_MEMARB_RR_EN
  memarb_owner_e     last_owner_q, last_owner_d;
  assign last_owner = last_owner_q;
`else
  assign last_owner = MEMARB_OWNER_IFU;
`endif

  rv32im_memarb_pick u_pick (
    .ifu_req_i    (bus.ifu_req_i),
    .lsu_req_i    (bus.lsu_req_i),
    .last_owner_i (last_owner),
    .valid_o      (pick_valid),
    .owner_o      (pick_owner)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    ifu_gnt      = 1'b0;
    lsu_gnt      = 1'b0;
`ifdef API_MEMARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      MEMARB_IDLE: begin
        // Grant is combinational so the requester can drop its request next cycle.
        if (pick_valid) begin
          state_d   = memarb_busy_state(pick_owner);
          mem_req_d = 1'b1;
`ifdef API_MEMARB_RR_EN
          last_owner_d = pick_owner;
`endif
          if (pick_owner == MEMARB_OWNER_LSU) begin
            lsu_gnt     = 1'b1;
            mem_we_d    = bus.lsu_we_i;
            mem_be_d    = bus.lsu_be_i;
            mem_addr_d  = bus.lsu_addr_i;
            mem_wdata_d = bus.lsu_wdata_i;
          end else begin
            ifu_gnt     = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = bus.ifu_addr_i;
            mem_wdata_d = '0;
          end
        end
      end
      MEMARB_BUSY_IFU: begin
        if (bus.mem_ready_i) begin
          ifu_rdata_d  = bus.mem_rdata_i;
          ifu_rvalid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = MEMARB_IDLE;
        end
      end
      MEMARB_BUSY_LSU: begin
        if (bus.mem_ready_i) begin
          if (!mem_we_q) begin
            lsu_rdata_d = bus.mem_rdata_i;
          end
          lsu_rvalid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = MEMARB_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = MEMARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= MEMARB_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
`ifdef API_MEMARB_RR_EN
      last_owner_q <= MEMARB_OWNER_IFU;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
`ifdef API_MEMARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign bus.ifu_gnt_o    = ifu_gnt;
  assign bus.lsu_gnt_o    = lsu_gnt;
  assign bus.ifu_rvalid_o = ifu_rvalid_q;
  assign bus.lsu_rvalid_o = lsu_rvalid_q;
  assign bus.ifu_rdata_o  = ifu_rdata_q;
  assign bus.lsu_rdata_o  = lsu_rdata_q;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_be_o     = mem_be_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// Bench for rv32im_mem_arbiter: vector table of single transactions, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_rv32im_mem_arbiter;
  import rv32im_mem_arbiter_pkg::*;

`ifdef API_MEMARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32im_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32), .BE_W(4)) bus ();

  rv32im_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .BE_W(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    bit          is_lsu;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned waits;
    logic [31:0] exp_rdata;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ifu_req_i   = 1'b0;
    bus.ifu_addr_i  = '0;
    bus.lsu_req_i   = 1'b0;
    bus.lsu_we_i    = 1'b0;
    bus.lsu_be_i    = '0;
    bus.lsu_addr_i  = '0;
    bus.lsu_wdata_i = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ifu_gnt"}, bus.ifu_gnt_o, 1'b0);
    chk1({tag, "_lsu_gnt"}, bus.lsu_gnt_o, 1'b0);
    chk1({tag, "_ifu_rvalid"}, bus.ifu_rvalid_o, 1'b0);
    chk1({tag, "_lsu_rvalid"}, bus.lsu_rvalid_o, 1'b0);
    chk1({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
    chk1({tag, "_mem_we"}, bus.mem_we_o, 1'b0);
    chk({tag, "_mem_be"}, {28'b0, bus.mem_be_o}, 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'h0);
    chk({tag, "_ifu_rdata"}, bus.ifu_rdata_o, 32'h0);
    chk({tag, "_lsu_rdata"}, bus.lsu_rdata_o, 32'h0);
  endtask

  // One transaction from idle: gnt at cycle 0, held request until ready, rvalid after.
  task automatic run_txn(input vec_t v, input string tag);
    if (v.is_lsu) begin
      bus.lsu_req_i   = 1'b1;
      bus.lsu_we_i    = v.we;
      bus.lsu_be_i    = v.be;
      bus.lsu_addr_i  = v.addr;
      bus.lsu_wdata_i = v.wdata;
    end else begin
      bus.ifu_req_i  = 1'b1;
      bus.ifu_addr_i = v.addr;
    end
    bus.mem_ready_i = 1'b0;
    smp();
    chk1({tag, "_gnt"}, v.is_lsu ? bus.lsu_gnt_o : bus.ifu_gnt_o, 1'b1);
    chk1({tag, "_other_gnt"}, v.is_lsu ? bus.ifu_gnt_o : bus.lsu_gnt_o, 1'b0);
    chk1({tag, "_req_c0"}, bus.mem_req_o, 1'b0);
    cyc();
    bus.ifu_req_i   = 1'b0;
    bus.lsu_req_i   = 1'b0;
    bus.ifu_addr_i  = ~v.addr;
    bus.lsu_addr_i  = ~v.addr;
    bus.lsu_we_i    = ~v.we;
    bus.lsu_be_i    = ~v.be;
    bus.lsu_wdata_i = ~v.wdata;
    for (int unsigned w = 0; w <= v.waits; w++) begin
      bus.mem_ready_i = (w == v.waits);
      bus.mem_rdata_i = v.rdata;
      smp();
      chk1($sformatf("%s_req_w%0d", tag, w), bus.mem_req_o, 1'b1);
      chk($sformatf("%s_addr_w%0d", tag, w), bus.mem_addr_o, v.addr);
      chk1($sformatf("%s_we_w%0d", tag, w), bus.mem_we_o, v.is_lsu ? v.we : 1'b0);
      chk($sformatf("%s_be_w%0d", tag, w), {28'b0, bus.mem_be_o}, {28'b0, v.is_lsu ? v.be : 4'hF});
      if (v.is_lsu) chk($sformatf("%s_wdata_w%0d", tag, w), bus.mem_wdata_o, v.wdata);
      chk1($sformatf("%s_early_rv_w%0d", tag, w), v.is_lsu ? bus.lsu_rvalid_o : bus.ifu_rvalid_o, 1'b0);
      cyc();
    end
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    smp();
    chk1({tag, "_rvalid"}, v.is_lsu ? bus.lsu_rvalid_o : bus.ifu_rvalid_o, 1'b1);
    chk1({tag, "_other_rvalid"}, v.is_lsu ? bus.ifu_rvalid_o : bus.lsu_rvalid_o, 1'b0);
    chk1({tag, "_req_done"}, bus.mem_req_o, 1'b0);
    chk({tag, "_rdata"}, v.is_lsu ? bus.lsu_rdata_o : bus.ifu_rdata_o, v.exp_rdata);
    cyc();
    smp();
    chk1({tag, "_rvalid_pulse"}, v.is_lsu ? bus.lsu_rvalid_o : bus.ifu_rvalid_o, 1'b0);
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[5];
  vec_t v;
  bit   exp_ord[4];

  // Random-phase reference state (owner: 0 idle, 1 IFU, 2 LSU).
  int          owner, win;
  bit          exp_irv, exp_lrv, n_irv, n_lrv, last_lsu, drop_i, drop_l;
  logic [31:0] m_addr, m_wdata, ifu_rd, lsu_rd;
  logic        m_we;
  logic [3:0]  m_be;

  initial begin
    vecs[0] = '{is_lsu:0, we:0, be:4'hF, addr:32'h0000_0100, wdata:32'h0,
                rdata:32'h00C0_FFEE, waits:0, exp_rdata:32'h00C0_FFEE};
    vecs[1] = '{is_lsu:1, we:0, be:4'hF, addr:32'h0000_0040, wdata:32'h0,
                rdata:32'h1234_5678, waits:1, exp_rdata:32'h1234_5678};
    vecs[2] = '{is_lsu:1, we:1, be:4'b0011, addr:32'h0000_0020, wdata:32'h0000_BEEF,
                rdata:32'hDEAD_DEAD, waits:3, exp_rdata:32'h1234_5678};
    vecs[3] = '{is_lsu:0, we:0, be:4'hF, addr:32'h0000_0104, wdata:32'h0,
                rdata:32'hA5A5_A5A5, waits:2, exp_rdata:32'hA5A5_A5A5};
    vecs[4] = '{is_lsu:1, we:0, be:4'b1000, addr:32'hFFFF_FFFC, wdata:32'h0,
                rdata:32'hFFFF_FFFF, waits:0, exp_rdata:32'hFFFF_FFFF};
    if (RR_EN) begin
      exp_ord[0] = 1; exp_ord[1] = 0; exp_ord[2] = 1; exp_ord[3] = 0;
    end else begin
      exp_ord[0] = 1; exp_ord[1] = 1; exp_ord[2] = 1; exp_ord[3] = 1;
    end

    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    smp();
    chk_reset_outputs("rst_in");
    cyc();
    rst_n = 1'b1;
    smp();
    chk_reset_outputs("rst_out");
    cyc();

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // mem_ready while idle must be ignored
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk1("idle_rdy_irv", bus.ifu_rvalid_o, 1'b0);
      chk1("idle_rdy_lrv", bus.lsu_rvalid_o, 1'b0);
      chk1("idle_rdy_req", bus.mem_req_o, 1'b0);
      chk("idle_rdy_ifu_rdata", bus.ifu_rdata_o, 32'hA5A5_A5A5);
      chk("idle_rdy_lsu_rdata", bus.lsu_rdata_o, 32'hFFFF_FFFF);
      cyc();
    end
    bus.mem_ready_i = 1'b0;

    // reset during BUSY_LSU
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b0;
    bus.lsu_be_i   = 4'hF;
    bus.lsu_addr_i = 32'h0000_0080;
    smp();
    chk1("rst_mid_gnt", bus.lsu_gnt_o, 1'b1);
    cyc();
    bus.lsu_req_i = 1'b0;
    smp();
    chk1("rst_mid_busy", bus.mem_req_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk1("rst_mid_req_drop", bus.mem_req_o, 1'b0);
    cyc();
    rst_n = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk1("rst_mid_no_rv", bus.lsu_rvalid_o, 1'b0);
      chk1("rst_mid_req", bus.mem_req_o, 1'b0);
      chk("rst_mid_rdata", bus.lsu_rdata_o, 32'h0);
      cyc();
    end
    bus.mem_ready_i = 1'b0;
    v = '{is_lsu:0, we:0, be:4'hF, addr:32'h0000_0200, wdata:32'h0,
          rdata:32'h1357_9BDF, waits:1, exp_rdata:32'h1357_9BDF};
    run_txn(v, "post_rst");

    // simultaneous requests: LSU first, IFU granted in the LSU rvalid cycle
    bus.ifu_req_i   = 1'b1;
    bus.ifu_addr_i  = 32'h0000_0300;
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b1;
    bus.lsu_be_i    = 4'hF;
    bus.lsu_addr_i  = 32'h0000_0400;
    bus.lsu_wdata_i = 32'h1111_2222;
    smp();
    chk1("conf_lsu_gnt", bus.lsu_gnt_o, 1'b1);
    chk1("conf_ifu_gnt0", bus.ifu_gnt_o, 1'b0);
    cyc();
    bus.lsu_req_i   = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h9999_9999;
    smp();
    chk("conf_lsu_addr", bus.mem_addr_o, 32'h0000_0400);
    chk1("conf_lsu_we", bus.mem_we_o, 1'b1);
    chk1("conf_ifu_gnt1", bus.ifu_gnt_o, 1'b0);
    cyc();
    bus.mem_ready_i = 1'b0;
    smp();
    chk1("conf_lsu_rv", bus.lsu_rvalid_o, 1'b1);
    chk1("conf_ifu_gnt2", bus.ifu_gnt_o, 1'b1);
    chk("conf_lsu_rdata", bus.lsu_rdata_o, 32'h0);
    cyc();
    bus.ifu_req_i   = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h0BAD_F00D;
    smp();
    chk("conf_ifu_addr", bus.mem_addr_o, 32'h0000_0300);
    chk1("conf_ifu_we", bus.mem_we_o, 1'b0);
    cyc();
    bus.mem_ready_i = 1'b0;
    smp();
    chk1("conf_ifu_rv", bus.ifu_rvalid_o, 1'b1);
    chk("conf_ifu_rdata", bus.ifu_rdata_o, 32'h0BAD_F00D);
    cyc();

    // both requesters held continuously for four transactions
    bus.ifu_req_i   = 1'b1;
    bus.ifu_addr_i  = 32'h0000_0500;
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b0;
    bus.lsu_be_i    = 4'hF;
    bus.lsu_addr_i  = 32'h0000_0600;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h0000_0077;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk1($sformatf("hold%0d_lsu_gnt", k), bus.lsu_gnt_o, exp_ord[k]);
      chk1($sformatf("hold%0d_ifu_gnt", k), bus.ifu_gnt_o, !exp_ord[k]);
      cyc();
      smp();
      chk1($sformatf("hold%0d_busy_gnt", k), bus.lsu_gnt_o | bus.ifu_gnt_o, 1'b0);
      chk($sformatf("hold%0d_addr", k), bus.mem_addr_o, exp_ord[k] ? 32'h0000_0600 : 32'h0000_0500);
      cyc();
    end
    bus.ifu_req_i   = 1'b0;
    bus.lsu_req_i   = 1'b0;
    bus.mem_ready_i = 1'b0;
    cyc();
    cyc();

    // randomized traffic against the reference model, from a fresh reset
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    owner = 0; exp_irv = 0; exp_lrv = 0; last_lsu = 0; drop_i = 0; drop_l = 0;
    ifu_rd = '0; lsu_rd = '0; m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0;
    for (int c = 0; c < 600; c++) begin
      if (drop_i) bus.ifu_req_i = 1'b0;
      else if (!bus.ifu_req_i && $urandom_range(2) == 0) begin
        bus.ifu_req_i  = 1'b1;
        bus.ifu_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (drop_l) bus.lsu_req_i = 1'b0;
      else if (!bus.lsu_req_i && $urandom_range(2) == 0) begin
        bus.lsu_req_i   = 1'b1;
        bus.lsu_we_i    = 1'($urandom_range(1));
        bus.lsu_be_i    = 4'($urandom_range(15));
        bus.lsu_addr_i  = $urandom() & 32'hFFFF_FFFC;
        bus.lsu_wdata_i = $urandom();
      end
      drop_i = 0;
      drop_l = 0;
      bus.mem_ready_i = ($urandom_range(2) == 0);
      bus.mem_rdata_i = $urandom();
      smp();

      win = 0;
      if (owner == 0) begin
        if (bus.ifu_req_i && bus.lsu_req_i) win = (RR_EN && last_lsu) ? 1 : 2;
        else if (bus.lsu_req_i) win = 2;
        else if (bus.ifu_req_i) win = 1;
      end
      chk1("rnd_ifu_gnt", bus.ifu_gnt_o, win == 1);
      chk1("rnd_lsu_gnt", bus.lsu_gnt_o, win == 2);
      chk1("rnd_mem_req", bus.mem_req_o, owner != 0);
      chk1("rnd_ifu_rv", bus.ifu_rvalid_o, exp_irv);
      chk1("rnd_lsu_rv", bus.lsu_rvalid_o, exp_lrv);
      chk("rnd_ifu_rdata", bus.ifu_rdata_o, ifu_rd);
      chk("rnd_lsu_rdata", bus.lsu_rdata_o, lsu_rd);
      if (owner != 0) begin
        chk("rnd_addr", bus.mem_addr_o, m_addr);
        chk1("rnd_we", bus.mem_we_o, m_we);
        chk("rnd_be", {28'b0, bus.mem_be_o}, {28'b0, m_be});
        if (owner == 2) chk("rnd_wdata", bus.mem_wdata_o, m_wdata);
      end

      n_irv = 0;
      n_lrv = 0;
      if (owner != 0 && bus.mem_ready_i) begin
        if (owner == 1) begin
          ifu_rd = bus.mem_rdata_i;
          n_irv  = 1;
        end else begin
          if (!m_we) lsu_rd = bus.mem_rdata_i;
          n_lrv = 1;
        end
        owner = 0;
      end else if (win == 2) begin
        owner = 2; last_lsu = 1; drop_l = 1;
        m_addr = bus.lsu_addr_i; m_we = bus.lsu_we_i; m_be = bus.lsu_be_i; m_wdata = bus.lsu_wdata_i;
      end else if (win == 1) begin
        owner = 1; last_lsu = 0; drop_i = 1;
        m_addr = bus.ifu_addr_i; m_we = 1'b0; m_be = 4'hF;
      end
      exp_irv = n_irv;
      exp_lrv = n_lrv;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
